// File: rtl/pixel_stream_tx_if.sv
// rtl/pixel_stream_tx_if.sv - pixel input handshake and timed output stream bundle
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

interface pixel_stream_tx_if;
  logic                     in_valid;
  logic [`PIXEL_SIZE-1:0]   in_data;
  logic                     in_ready;
  logic                     en;
  logic                     hsync;
  logic                     vsync;
  logic [`PIXEL_SIZE-1:0]   data;

  modport master (
    input  in_valid, in_data,
    output in_ready, en, hsync, vsync, data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, en, hsync, vsync, data
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - frame timing generator that paces upstream pixels into a line/frame stream
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
`ifndef FRAME_WIDTH
`define FRAME_WIDTH 640
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 480
`endif

module pixel_stream_tx #(
  parameter int WIDTH   = `FRAME_WIDTH,
  parameter int HEIGHT  = `FRAME_HEIGHT,
  parameter int H_BLANK = 4,
  parameter int V_BLANK = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  pixel_stream_tx_if.master   bus,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame
);

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, ACTIVE, HBLANK, VBLANK} state_t;

  state_t               state, state_nx;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [BW-1:0]        bcnt;
  logic                 in_ready_c, handshake;
  logic                 en_nx, hsync_nx, vsync_nx, fd_nx;
  logic                 en_q, hsync_q, vsync_q;
  logic [`PIXEL_SIZE-1:0] data_q;

  logic x_last, y_last, h_last, v_last;
  assign x_last    = (x == XW'(WIDTH - 1));
  assign y_last    = (y == YW'(HEIGHT - 1));
  assign h_last    = (bcnt == BW'(H_BLANK - 1));
  assign v_last    = (bcnt == BW'(V_BLANK - 1));
  assign handshake = bus.in_valid & in_ready_c;

  // State register plus the x/y/blank counters that pace it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      bcnt  <= '0;
      frame <= '0;
    end else begin
      state <= state_nx;
      case (state)
        VSYNC:  y <= '0;
        HSYNC:  x <= '0;
        ACTIVE: if (handshake) x <= x_last ? '0 : x + 1'b1;
        HBLANK: begin
          if (h_last) begin
            bcnt <= '0;
            if (!y_last) y <= y + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        VBLANK: begin
          if (v_last) begin
            bcnt  <= '0;
            frame <= frame + 16'd1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = VSYNC;
      VSYNC:   state_nx = HSYNC;
      HSYNC:   state_nx = ACTIVE;
      ACTIVE:  if (handshake && x_last) state_nx = HBLANK;
      HBLANK:  if (h_last) state_nx = y_last ? VBLANK : HSYNC;
      VBLANK:  if (v_last) state_nx = start ? VSYNC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = (state == ACTIVE);
    busy       = (state != IDLE);
    en_nx      = handshake;
    hsync_nx   = (state == HSYNC);
    vsync_nx   = (state == VSYNC);
    fd_nx      = (state == VBLANK) && v_last;
  end

  // Stream outputs are registered one cycle behind the state that produces them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      frame_done <= 1'b0;
      data_q     <= '0;
    end else begin
      en_q       <= en_nx;
      hsync_q    <= hsync_nx;
      vsync_q    <= vsync_nx;
      frame_done <= fd_nx;
      if (handshake) data_q <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.en       = en_q;
  assign bus.hsync    = hsync_q;
  assign bus.vsync    = vsync_q;
  assign bus.data     = data_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - scoreboard bench for pixel_stream_tx on a 4x2 frame
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module tb_pixel_stream_tx;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int VB = 3;
  localparam int FRAME_LEN = 1 + H * (1 + W + HB) + VB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame;

  pixel_stream_tx_if bus ();

  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor / scoreboard state
  logic [`PIXEL_SIZE-1:0] q[$];
  logic [`PIXEL_SIZE-1:0] last_data = '0;
  logic [`PIXEL_SIZE-1:0] exp_px;
  int cyc = 0, acc = 0;
  int vs_n = 0, hs_n = 0, en_n = 0, fd_n = 0;
  int vs_last = 0, vs_prev = 0, fd_last = 0;
  int en_cyc[int];
  bit lopen = 0, line_active = 0;
  int lhs = 0, px_line = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      q.delete();
      lopen = 0; lhs = 0; line_active = 0; px_line = 0;
      last_data = '0;
    end else begin
      chk("excl", 32'((bus.en & bus.hsync) | (bus.en & bus.vsync) | (bus.hsync & bus.vsync)), 32'd0);
      if (bus.vsync) begin
        vs_n++; vs_prev = vs_last; vs_last = cyc;
      end
      if (bus.hsync) begin
        if (line_active) chk("px_per_line", 32'(px_line), 32'(W));
        line_active = 1; px_line = 0; hs_n++;
        lopen = 1; lhs = 0;
      end
      if (bus.en) begin
        en_n++; px_line++; en_cyc[en_n] = cyc;
        if (q.size() == 0) chk("en_unexpected", 32'd1, 32'd0);
        else begin
          exp_px = q.pop_front();
          chk("data", 32'(bus.data), 32'(exp_px));
          last_data = exp_px;
        end
      end else begin
        chk("data_hold", 32'(bus.data), 32'(last_data));
      end
      if (frame_done) begin
        fd_n++; fd_last = cyc;
        if (line_active) chk("px_per_line", 32'(px_line), 32'(W));
        line_active = 0;
      end
      chk("in_ready", 32'(bus.in_ready), 32'(lopen));
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(bus.in_data);
        acc++; lhs++;
        if (lhs == W) lopen = 0;
      end
    end
  end

  initial begin
    bus.in_data = 1;
    forever begin
      @(posedge clk);
      #1 bus.in_data = `PIXEL_SIZE'(acc + 1);
    end
  end

  function automatic int cnt_sel(input int sel);
    case (sel)
      0:       return fd_n;
      1:       return vs_n;
      2:       return en_n;
      default: return hs_n;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int target, input int budget, input string tag);
    int k = 0;
    while (cnt_sel(sel) < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(cnt_sel(sel) >= target), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"},    32'(bus.en),       32'd0);
    chk({tag, "_hsync"}, 32'(bus.hsync),    32'd0);
    chk({tag, "_vsync"}, 32'(bus.vsync),    32'd0);
    chk({tag, "_fd"},    32'(frame_done),   32'd0);
    chk({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy),         32'd0);
    chk({tag, "_data"},  32'(bus.data),     32'd0);
    chk({tag, "_frame"}, 32'(frame),        32'd0);
  endtask

  int s_vs, s_hs, s_en, s_fd, s_acc, f1, k;

  initial begin
    reset_n = 1'b1; start = 1'b0; bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("idle_busy", 32'(busy), 32'd0);

    // Single frame, one-cycle start pulse, no stalls
    bus.in_valid = 1'b1;
    s_vs = vs_n; s_hs = hs_n; s_en = en_n; s_fd = fd_n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_cnt(0, s_fd + 1, 40, "t1_fd_timeout");
    chk("t1_vsync_cnt", 32'(vs_n - s_vs), 32'd1);
    chk("t1_hsync_cnt", 32'(hs_n - s_hs), 32'd2);
    chk("t1_en_cnt",    32'(en_n - s_en), 32'd8);
    chk("t1_frame_len", 32'(fd_last - vs_last + 1), 32'(FRAME_LEN));
    chk("t1_frame",     32'(frame), 32'd1);
    chk("t1_busy",      32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1 chk("t1_fd_once", 32'(fd_n - s_fd), 32'd1);

    // Three-cycle upstream stall after the second pixel of line 0
    s_en = en_n; s_fd = fd_n; s_acc = acc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (acc - s_acc < 2 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t2_px2_timeout", 32'(acc - s_acc >= 2), 32'd1);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b1;
    wait_cnt(0, s_fd + 1, 50, "t2_fd_timeout");
    chk("t2_en_cnt",     32'(en_n - s_en), 32'd8);
    chk("t2_gap_before", 32'(en_cyc[s_en + 2] - en_cyc[s_en + 1]), 32'd1);
    chk("t2_gap_stall",  32'(en_cyc[s_en + 3] - en_cyc[s_en + 2]), 32'd4);
    chk("t2_frame_len",  32'(fd_last - vs_last + 1), 32'(FRAME_LEN + 3));
    chk("t2_frame",      32'(frame), 32'd2);

    // start held: back-to-back frames, then start dropped mid second frame
    s_vs = vs_n; s_en = en_n; s_fd = fd_n;
    @(posedge clk); #1 start = 1'b1;
    wait_cnt(0, s_fd + 1, 40, "t3_fd1_timeout");
    f1 = fd_last;
    chk("t3_busy_between", 32'(busy), 32'd1);
    wait_cnt(1, s_vs + 2, 10, "t3_vs2_timeout");
    chk("t3_vs_after_fd",  32'(vs_last - f1), 32'd1);
    chk("t3_vs_period",    32'(vs_last - vs_prev), 32'(FRAME_LEN));
    @(posedge clk); #1 start = 1'b0;
    wait_cnt(0, s_fd + 2, 40, "t3_fd2_timeout");
    chk("t3_frame",   32'(frame), 32'd4);
    chk("t3_en_cnt",  32'(en_n - s_en), 32'd16);
    chk("t3_busy_end", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1 chk("t3_no_restart", 32'(vs_n - s_vs), 32'd2);

    // Asynchronous reset in the second active line, start held high
    s_en = en_n;
    @(posedge clk); #1 start = 1'b1;
    wait_cnt(2, s_en + 6, 40, "t5_px6_timeout");
    @(posedge clk); #3 reset_n = 1'b0;
    #1 check_all_zero("t5_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    s_hs = hs_n; s_en = en_n; s_vs = vs_n; s_fd = fd_n;
    wait_cnt(1, s_vs + 1, 10, "t5_vs_timeout");
    chk("t5_first_is_vsync_hs", 32'(hs_n - s_hs), 32'd0);
    chk("t5_first_is_vsync_en", 32'(en_n - s_en), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    wait_cnt(0, s_fd + 1, 40, "t5_fd_timeout");
    chk("t5_en_cnt", 32'(en_n - s_en), 32'd8);
    chk("t5_frame",  32'(frame), 32'd1);
    chk("t5_busy",   32'(busy), 32'd0);

    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 Parameter WIDTH, default `FRAME_WIDTH, active pixels per line (>=2).
REQ-002 Parameter HEIGHT, default `FRAME_HEIGHT, active lines per frame (>=1).
REQ-003 Parameter H_BLANK, default 4, idle cycles after each line (>=1).
REQ-004 Parameter V_BLANK, default 8, idle cycles after last line of a frame (>=1).
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 reset_n  input  1  reset is asynchronous and active-low.
REQ-007 start  input  1  level; high = transmit frames continuously, low = stop after current frame.
REQ-008 in_valid  input  1  upstream pixel available.
REQ-009 in_data  input  `PIXEL_SIZE  upstream pixel, {B,G,R} packing, R in [7:0].
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 en  output  1  registered pixel-valid strobe to downstream stream consumer.
REQ-012 hsync  output  1  registered one-cycle line-start marker.
REQ-013 vsync  output  1  registered one-cycle frame-start marker.
REQ-014 data  output  `PIXEL_SIZE  registered pixel, meaningful only when en=1.
REQ-015 busy  output  1  high whenever FSM is not IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at end of each frame's vertical blank.
REQ-017 frame  output  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-018 FSM states SHALL be IDLE, VSYNC, HSYNC, ACTIVE, HBLANK, VBLANK.
REQ-019 IDLE: start=1 -> VSYNC; else stay.
REQ-020 VSYNC lasts exactly 1 cycle -> HSYNC; y counter cleared to 0.
REQ-021 HSYNC lasts exactly 1 cycle -> ACTIVE; x counter cleared to 0.
REQ-022 ACTIVE: in_ready=1 only in this state; handshake = in_valid & in_ready.
REQ-023 Each handshake increments x; handshake at x=WIDTH-1 -> HBLANK.
REQ-024 in_valid=0 in ACTIVE = stall: no x increment, en=0 next cycle, no timeout.
REQ-025 HBLANK lasts exactly H_BLANK cycles; then y=HEIGHT-1 -> VBLANK, else y+1 and -> HSYNC.
REQ-026 VBLANK lasts exactly V_BLANK cycles; on last cycle frame_done pulses (registered, next cycle) and frame increments.
REQ-027 VBLANK exit: start=1 -> VSYNC (back-to-back frames, no IDLE cycle); start=0 -> IDLE.
REQ-028 start deassertion mid-frame SHALL NOT truncate the frame.
REQ-029 Output latency: en/data 1 cycle after handshake; vsync 1 cycle after VSYNC state; hsync 1 cycle after HSYNC state.
REQ-030 en, hsync, vsync SHALL be mutually exclusive every cycle.
REQ-031 data SHALL hold last accepted pixel when en=0.
REQ-032 Blanking counter sized for max(H_BLANK, V_BLANK); x/y counters sized for WIDTH/HEIGHT, compare on exact terminal value.
REQ-033 Unstalled frame length SHALL be 1 + HEIGHT*(1+WIDTH+H_BLANK) + V_BLANK cycles.

Reset
REQ-034 reset_n low: state=IDLE, x=y=0, blank counter=0, frame=0; en, hsync, vsync, frame_done, in_ready, busy = 0; data = 0.
REQ-035 Reset asserted mid-frame aborts immediately; after release, transmission restarts with VSYNC only if start=1.
REQ-036 No handshake SHALL occur while reset_n is low.

Verification (WIDTH=4, HEIGHT=2, H_BLANK=2, V_BLANK=3)
REQ-037 start=1 one cycle, in_valid held 1, in_data=1,2,...: vsync once, hsync twice, en high 8 cycles with data 1..8, frame_done once 18 cycles after first vsync, frame=1, then IDLE.
REQ-038 in_valid dropped 3 cycles mid-line: en gaps exactly 3 cycles, still 4 pixels per line, frame length 21 cycles.
REQ-039 start held 1: second vsync 1 cycle after first frame's VBLANK ends; frame=2 after two frames; never IDLE between.
REQ-040 start low after first vsync: full frame of 8 pixels still emitted, then busy=0.
REQ-041 reset_n pulsed low during ACTIVE line 1: all outputs 0 asynchronously, frame=0; after release with start=1 new frame begins with vsync.
REQ-042 Every cycle: at most one of en/hsync/vsync high; in_ready high only between hsync and that line's 4th handshake.
